// File: rtl/jtframe_prog_pkg.sv
// Shared types and constants for the ioctl-to-SDRAM programming router.
package jtframe_prog_pkg;

   // Widest word address an entry can carry: a 25-bit byte offset halves to 24 bits.
   localparam int ENTRY_AW = 24;

   // Active-low byte-lane write masks.
   localparam logic [1:0] LANE0_MASK = 2'b10;
   localparam logic [1:0] LANE1_MASK = 2'b01;
   localparam logic [1:0] IDLE_MASK  = 2'b11;

   typedef struct packed {
      logic [1:0]          ba;
      logic [ENTRY_AW-1:0] addr;
      logic [7:0]          data;
      logic                lane;
   } prog_entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } prog_state_t;

   // Mask that enables only the selected byte lane.
   function automatic logic [1:0] lane_mask(input logic lane);
      if (lane) begin
         lane_mask = LANE1_MASK;
      end else begin
         lane_mask = LANE0_MASK;
      end
   endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Synchronous FIFO with occupancy counter; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module jtframe_prog_fifo #(
   parameter int W  = 35,
   parameter int AW = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok_s, pop_ok_s;

   // Status flags, accepted operations and next pointer/count values.
   always_comb begin
      full      = (cnt_q == (AW+1)'(DEPTH));
      empty     = (cnt_q == '0);
      pop_ok_s  = pop & ~empty;
      push_ok_s = push & (~full | pop_ok_s);
      dout      = mem_q[rd_ptr_q];
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards all contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/jtframe_prog_router.sv
// Turns the byte-wide ioctl download stream into masked 16-bit SDRAM
// programming writes, bank-routed by region boundaries and buffered by a FIFO.
module jtframe_prog_router #(
   parameter int          SDRAMW    = 23,
   parameter int          HEADER    = 0,
   parameter logic [24:0] BA1_START = 25'h40_0000,
   parameter logic [24:0] BA2_START = 25'h80_0000,
   parameter logic [24:0] BA3_START = 25'hC0_0000,
   parameter int          SWAB      = 0,
   parameter int          FIFO_AW   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              downloading,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              ioctl_wr,
   output logic [SDRAMW-1:0] prog_addr,
   output logic [15:0]       prog_data,
   output logic [1:0]        prog_mask,
   output logic [1:0]        prog_ba,
   output logic              prog_we,
   input  logic              prog_rdy,
   output logic              dwnld_busy,
   output logic              overflow
);
   import jtframe_prog_pkg::*;

   localparam logic [24:0] HDR      = 25'(HEADER);
   localparam logic        SWAB_BIT = (SWAB != 0);

   logic [25:0]       hdr_sub_s;
   logic [24:0]       eff_s, off_s;
   logic [1:0]        ba_s;
   prog_entry_t       acc_d, acc_q, head_s;
   logic              acc_vld_d, acc_vld_q;
   logic              fifo_full_s, fifo_empty_s, pop_s;
   prog_state_t       state_d, state_q;
   logic [SDRAMW-1:0] prog_addr_d, prog_addr_q;
   logic [15:0]       prog_data_d, prog_data_q;
   logic [1:0]        prog_mask_d, prog_mask_q;
   logic [1:0]        prog_ba_d, prog_ba_q;
   logic              prog_we_d, prog_we_q;
   logic              overflow_d, overflow_q;
   logic              dwnld_busy_d, dwnld_busy_q;
   logic              dl_q;

   // Header strip and bank decode; a borrow out of the subtraction marks a header byte.
   always_comb begin
      hdr_sub_s = {1'b0, ioctl_addr} - {1'b0, HDR};
      eff_s     = hdr_sub_s[24:0];
      if (eff_s >= BA3_START) begin
         ba_s  = 2'd3;
         off_s = eff_s - BA3_START;
      end else if (eff_s >= BA2_START) begin
         ba_s  = 2'd2;
         off_s = eff_s - BA2_START;
      end else if (eff_s >= BA1_START) begin
         ba_s  = 2'd1;
         off_s = eff_s - BA1_START;
      end else begin
         ba_s  = 2'd0;
         off_s = eff_s;
      end
      acc_vld_d  = ioctl_wr & downloading & ~hdr_sub_s[25];
      acc_d.ba   = ba_s;
      acc_d.addr = off_s[24:1];
      acc_d.data = ioctl_dout;
      acc_d.lane = off_s[0] ^ SWAB_BIT;
   end

   // Accept stage register in front of the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_vld_q <= 1'b0;
         acc_q     <= '0;
      end else begin
         acc_vld_q <= acc_vld_d;
         acc_q     <= acc_d;
      end
   end

   jtframe_prog_fifo #(
      .W  ($bits(prog_entry_t)),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (acc_vld_q),
      .din   (acc_q),
      .pop   (pop_s),
      .dout  (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Write FSM next state, prog_* loads, sticky overflow and busy tracking.
   always_comb begin
      state_d     = state_q;
      prog_addr_d = prog_addr_q;
      prog_data_d = prog_data_q;
      prog_mask_d = prog_mask_q;
      prog_ba_d   = prog_ba_q;
      prog_we_d   = prog_we_q;
      pop_s       = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty_s) begin
               pop_s       = 1'b1;
               prog_addr_d = SDRAMW'(head_s.addr);
               prog_data_d = {head_s.data, head_s.data};
               prog_mask_d = lane_mask(head_s.lane);
               prog_ba_d   = head_s.ba;
               prog_we_d   = 1'b1;
               state_d     = WRITE;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (prog_rdy) begin
               prog_we_d = 1'b0;
               state_d   = IDLE;
            end else begin
               state_d = WRITE;
            end
         end
         default: begin
            prog_we_d = 1'b0;
            state_d   = IDLE;
         end
      endcase

      // A new download window clears the loss flag; otherwise it only sets.
      if (downloading && !dl_q) begin
         overflow_d = 1'b0;
      end else if (acc_vld_q && fifo_full_s && !pop_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end

      dwnld_busy_d = downloading | ~fifo_empty_s | (state_q == WRITE) | acc_vld_q;
   end

   // All FSM and output state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         prog_addr_q  <= '0;
         prog_data_q  <= 16'h0000;
         prog_mask_q  <= IDLE_MASK;
         prog_ba_q    <= 2'd0;
         prog_we_q    <= 1'b0;
         overflow_q   <= 1'b0;
         dwnld_busy_q <= 1'b0;
         dl_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         prog_addr_q  <= prog_addr_d;
         prog_data_q  <= prog_data_d;
         prog_mask_q  <= prog_mask_d;
         prog_ba_q    <= prog_ba_d;
         prog_we_q    <= prog_we_d;
         overflow_q   <= overflow_d;
         dwnld_busy_q <= dwnld_busy_d;
         dl_q         <= downloading;
      end
   end

   assign prog_addr  = prog_addr_q;
   assign prog_data  = prog_data_q;
   assign prog_mask  = prog_mask_q;
   assign prog_ba    = prog_ba_q;
   assign prog_we    = prog_we_q;
   assign overflow   = overflow_q;
   assign dwnld_busy = dwnld_busy_q;

endmodule

// File: tb/tb_jtframe_prog_router.sv
// Directed bench for jtframe_prog_router: three instances (default, SWAB=1,
// HEADER=16) share the ioctl bus; each has its own downloading line.
module tb_jtframe_prog_router;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  dl;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wr;
   logic        prog_rdy;

   logic [22:0] addr_0, addr_1, addr_2;
   logic [15:0] data_0, data_1, data_2;
   logic [1:0]  mask_0, mask_1, mask_2;
   logic [1:0]  ba_0, ba_1, ba_2;
   logic        we_0, we_1, we_2;
   logic        busy_0, busy_1, busy_2;
   logic        ovf_0, ovf_1, ovf_2;

   int          sel;
   logic [22:0] c_addr;
   logic [15:0] c_data;
   logic [1:0]  c_mask, c_ba;
   logic        c_we, c_busy, c_ovf;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   jtframe_prog_router dut (
      .clk(clk), .rst(rst), .downloading(dl[0]), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .prog_addr(addr_0),
      .prog_data(data_0), .prog_mask(mask_0), .prog_ba(ba_0), .prog_we(we_0),
      .prog_rdy(prog_rdy), .dwnld_busy(busy_0), .overflow(ovf_0)
   );

   jtframe_prog_router #(.SWAB(1)) dut_swab (
      .clk(clk), .rst(rst), .downloading(dl[1]), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .prog_addr(addr_1),
      .prog_data(data_1), .prog_mask(mask_1), .prog_ba(ba_1), .prog_we(we_1),
      .prog_rdy(prog_rdy), .dwnld_busy(busy_1), .overflow(ovf_1)
   );

   jtframe_prog_router #(.HEADER(16)) dut_hdr (
      .clk(clk), .rst(rst), .downloading(dl[2]), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .prog_addr(addr_2),
      .prog_data(data_2), .prog_mask(mask_2), .prog_ba(ba_2), .prog_we(we_2),
      .prog_rdy(prog_rdy), .dwnld_busy(busy_2), .overflow(ovf_2)
   );

   // Route the selected instance's outputs to the checking signals.
   always_comb begin
      case (sel)
         1: begin
            c_addr = addr_1; c_data = data_1; c_mask = mask_1; c_ba = ba_1;
            c_we = we_1; c_busy = busy_1; c_ovf = ovf_1;
         end
         2: begin
            c_addr = addr_2; c_data = data_2; c_mask = mask_2; c_ba = ba_2;
            c_we = we_2; c_busy = busy_2; c_ovf = ovf_2;
         end
         default: begin
            c_addr = addr_0; c_data = data_0; c_mask = mask_0; c_ba = ba_0;
            c_we = we_0; c_busy = busy_0; c_ovf = ovf_0;
         end
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   // Wait (bounded) for prog_we, check the write, then ack it 3 cycles later.
   task automatic do_write(input string tag, input logic [1:0] eba, input logic [22:0] eaddr,
                           input logic [15:0] edata, input logic [1:0] emask);
      int n;
      n = 0;
      while (!c_we && n < 30) begin
         tick();
         n++;
      end
      chk({tag, "_we"}, {31'd0, c_we}, 32'd1);
      chk({tag, "_ba"}, {30'd0, c_ba}, {30'd0, eba});
      chk({tag, "_addr"}, {9'd0, c_addr}, {9'd0, eaddr});
      chk({tag, "_data"}, {16'd0, c_data}, {16'd0, edata});
      chk({tag, "_mask"}, {30'd0, c_mask}, {30'd0, emask});
      repeat (2) tick();
      chk({tag, "_hold"}, {16'd0, c_data}, {16'd0, edata});
      prog_rdy = 1'b1;
      tick();
      prog_rdy = 1'b0;
      chk({tag, "_wefall"}, {31'd0, c_we}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [7:0] b;
      sel = 0; rst = 1'b1; dl = 3'b000; ioctl_wr = 1'b0;
      ioctl_addr = 25'd0; ioctl_dout = 8'h00; prog_rdy = 1'b0;
      repeat (3) tick();
      chk("rst_we",   {31'd0, c_we},   32'd0);
      chk("rst_addr", {9'd0, c_addr},  32'd0);
      chk("rst_data", {16'd0, c_data}, 32'd0);
      chk("rst_mask", {30'd0, c_mask}, 32'd3);
      chk("rst_ba",   {30'd0, c_ba},   32'd0);
      chk("rst_ovf",  {31'd0, c_ovf},  32'd0);
      chk("rst_busy", {31'd0, c_busy}, 32'd0);
      rst = 1'b0;
      tick();

      // Two bytes into one word, low lane then high lane.
      dl = 3'b001;
      tick();
      chk("busy_dl", {31'd0, c_busy}, 32'd1);
      send_byte(25'd0, 8'h11);
      send_byte(25'd1, 8'h22);
      do_write("t1a", 2'd0, 23'd0, 16'h1111, 2'b10);
      do_write("t1b", 2'd0, 23'd0, 16'h2222, 2'b01);

      // Exact latency: strobe sampled, +1 into FIFO, +1 to prog_we.
      send_byte(25'h40_0003, 8'hAB);
      tick();
      chk("lat_we0", {31'd0, c_we}, 32'd0);
      tick();
      chk("lat_we1", {31'd0, c_we}, 32'd1);
      do_write("t2", 2'd1, 23'd1, 16'hABAB, 2'b01);

      // Region boundaries.
      send_byte(25'h3F_FFFF, 8'h5A);
      do_write("b0top", 2'd0, 23'h1F_FFFF, 16'h5A5A, 2'b01);
      send_byte(25'h80_0002, 8'h3C);
      do_write("b2", 2'd2, 23'd1, 16'h3C3C, 2'b10);
      send_byte(25'hC0_0000, 8'hC3);
      do_write("b3", 2'd3, 23'd0, 16'hC3C3, 2'b10);
      send_byte(25'h1FF_FFFF, 8'h96);
      do_write("b3top", 2'd3, 23'h9F_FFFF, 16'h9696, 2'b01);

      // Swapped lanes.
      dl = 3'b010; sel = 1;
      tick();
      send_byte(25'h40_0003, 8'hAB);
      do_write("swab", 2'd1, 23'd1, 16'hABAB, 2'b10);
      send_byte(25'd0, 8'h77);
      do_write("swab0", 2'd0, 23'd0, 16'h7777, 2'b01);

      // Header discard.
      dl = 3'b100; sel = 2;
      tick();
      for (int i = 0; i < 16; i++) begin
         send_byte(25'(i), 8'(i));
      end
      repeat (8) tick();
      chk("hdr_none", {31'd0, c_we}, 32'd0);
      send_byte(25'd16, 8'h99);
      do_write("hdr16", 2'd0, 23'd0, 16'h9999, 2'b10);
      send_byte(25'd17, 8'h98);
      do_write("hdr17", 2'd0, 23'd0, 16'h9898, 2'b01);

      // Overflow: 10 back-to-back bytes with prog_rdy held low.
      dl = 3'b001; sel = 0;
      tick();
      for (int i = 0; i < 10; i++) begin
         ioctl_addr = 25'(i);
         ioctl_dout = 8'h30 + 8'(i);
         ioctl_wr   = 1'b1;
         tick();
      end
      ioctl_wr = 1'b0;
      repeat (4) tick();
      chk("ovf_set", {31'd0, c_ovf}, 32'd1);
      for (int i = 0; i < 9; i++) begin
         b = 8'h30 + 8'(i);
         do_write("ovf_wr", 2'd0, 23'(i / 2), {b, b}, (i % 2 == 1) ? 2'b01 : 2'b10);
      end
      repeat (6) tick();
      chk("ovf_no10", {31'd0, c_we}, 32'd0);
      chk("ovf_sticky", {31'd0, c_ovf}, 32'd1);
      dl = 3'b000;
      tick();
      dl = 3'b001;
      repeat (2) tick();
      chk("ovf_clr", {31'd0, c_ovf}, 32'd0);

      // Drain after downloading falls: one write in flight plus 4 queued.
      for (int i = 0; i < 5; i++) begin
         send_byte(25'h10 + 25'(i), 8'h50 + 8'(i));
      end
      repeat (4) tick();
      dl = 3'b000;
      tick();
      chk("drain_busy", {31'd0, c_busy}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         b = 8'h50 + 8'(i);
         do_write("drain", 2'd0, 23'((16 + i) / 2), {b, b}, (i % 2 == 1) ? 2'b01 : 2'b10);
         chk("drain_busy_hold", {31'd0, c_busy}, 32'd1);
      end
      tick();
      chk("drain_busy_fall", {31'd0, c_busy}, 32'd0);

      // Reset in the middle of a write with 3 entries queued.
      dl = 3'b001;
      tick();
      for (int i = 0; i < 4; i++) begin
         send_byte(25'h20 + 25'(i), 8'h60 + 8'(i));
      end
      repeat (4) tick();
      chk("mid_we", {31'd0, c_we}, 32'd1);
      dl = 3'b000;
      rst = 1'b1;
      tick();
      chk("mid_rst_we",   {31'd0, c_we},   32'd0);
      chk("mid_rst_busy", {31'd0, c_busy}, 32'd0);
      chk("mid_rst_mask", {30'd0, c_mask}, 32'd3);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         prog_rdy = 1'b1;
         tick();
         prog_rdy = 1'b0;
         repeat (3) tick();
         chk("post_rst_we", {31'd0, c_we}, 32'd0);
      end
      chk("post_rst_busy", {31'd0, c_busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/jtframe_prog_router.md
Name: jtframe_prog_router

Overview:
- Converts the byte-wide ioctl download stream (SPI loader, 8-bit, byte addresses) into masked 16-bit SDRAM programming writes on prog_*, routed to one of four banks by parametrised region boundaries.
- A small FIFO absorbs bytes while the SDRAM controller is busy.
- Its busy output drives the board-level downloading input, so game reset is held until the last buffered byte is committed.

Parameters:
- SDRAMW, 23, word address width of prog_addr.
- HEADER, 0, number of leading file bytes to discard (ROM header).
- BA1_START, 25'h40_0000, first byte offset (after header) mapped to bank 1; even.
- BA2_START, 25'h80_0000, first byte offset mapped to bank 2; even; >= BA1_START.
- BA3_START, 25'hC0_0000, first byte offset mapped to bank 3; even; >= BA2_START.
- SWAB, 0, 1 = swap byte lanes (even byte goes to the high lane).
- FIFO_AW, 3, log2 of FIFO depth (depth 8 by default).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- downloading, in, 1, ioctl download window active.
- ioctl_addr, in, 25, byte address.
- ioctl_dout, in, 8, byte data.
- ioctl_wr, in, 1, one-cycle byte strobe.
- prog_addr, out, SDRAMW, word address within the bank.
- prog_data, out, 16, byte replicated on both lanes.
- prog_mask, out, 2, active-low byte write mask.
- prog_ba, out, 2, bank select.
- prog_we, out, 1, write request, held high until acknowledged.
- prog_rdy, in, 1, one-cycle write-complete pulse from the SDRAM controller.
- dwnld_busy, out, 1, download or drain in progress.
- overflow, out, 1, sticky: a byte was lost to a full FIFO.

Behaviour:
- Reset: FIFO empty, state IDLE, prog_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prog_ba=0, overflow=0, dwnld_busy=0.
- Accept: ioctl_wr & downloading, registered in one cycle.
  - If ioctl_addr < HEADER, discard.
  - Otherwise eff = ioctl_addr - HEADER.
  - ba = 3 if eff >= BA3_START, else 2 if eff >= BA2_START, else 1 if eff >= BA1_START, else 0.
  - off = eff - start(ba); word address = off[SDRAMW:1]; upper bits are truncated silently.
  - lane = off[0] ^ SWAB.
  - Push {ba, word address, byte, lane}.
- ioctl_wr while downloading is low is ignored.
- FIFO: 2^FIFO_AW entries with a count register.
  - Push while full without a same-cycle pop: byte dropped, overflow set.
  - Push and pop in the same cycle while full: push accepted, count unchanged.
- overflow clears only on rst or on the rising edge of downloading.
- FSM:
  - IDLE: if FIFO is non-empty, pop the head, load the prog_* registers, set prog_we=1, go to WRITE (one cycle from a non-empty FIFO to prog_we).
  - WRITE: hold all prog_* outputs stable. On prog_rdy: prog_we=0 the next cycle, go to IDLE. A new write therefore issues no earlier than two cycles after prog_rdy.
  - prog_rdy seen in IDLE is ignored.
- Mask: lane 0 -> prog_mask=2'b10 (low byte); lane 1 -> 2'b01 (high byte). prog_data = {byte, byte}.
- dwnld_busy = downloading | FIFO non-empty | (state == WRITE) | accept-stage valid. It is registered, so it falls one cycle after the final prog_rdy when downloading is already low.
- downloading falling with data pending: draining continues to completion.
- rst mid-write: prog_we drops on the next edge and FIFO contents are discarded.
- Peak throughput: the ioctl byte rate must stay below the SDRAM write rate on average; overflow reports violations.

Decomposition:
- Package jtframe_prog_pkg:
  - typedef of the entry struct {ba[1:0], addr[SDRAMW-1:0], data[7:0], lane}.
  - FSM enum {IDLE, WRITE}.
  - Localparam mask constants LANE0_MASK=2'b10 and LANE1_MASK=2'b01.
- One natural sub-module: jtframe_prog_fifo, a synchronous FIFO parametrised by width and FIFO_AW, with full, empty and same-cycle push/pop.
- Address decode and the FSM stay in the top.

Test Plan:
- Default params, bytes 0x11 @0 and 0x22 @1, prog_rdy 3 cycles after each prog_we -> two writes: ba=0, addr=0, data=16'h1111, mask=2'b10; then ba=0, addr=0, data=16'h2222, mask=2'b01.
- Byte 0xAB @25'h40_0003 -> ba=1, addr=1, mask=2'b01. Repeat with SWAB=1 -> mask=2'b10.
- HEADER=16: writes @0..15 produce no prog_we; byte @16 -> ba=0, addr=0, mask=2'b10.
- Hold prog_rdy low and stream 10 bytes with FIFO_AW=3 -> overflow=1, and only the first 9 writes appear once prog_rdy resumes (8 buffered + 1 in WRITE). Next downloading rising edge -> overflow=0.
- downloading falls while 4 entries are queued -> dwnld_busy stays 1 through 4 more writes and falls 1 cycle after the last prog_rdy.
- Assert rst during WRITE with 3 entries queued -> next cycle prog_we=0, dwnld_busy=0, and no further writes after prog_rdy pulses.
